req_arbiter4: RTL and testbench

//   Shares one resource among 4 requesters, one owner at a time.

---
 rtl/arb_defs.sv | 12 +
 rtl/rot_pri_enc4.sv | 25 ++
 rtl/req_arbiter4.sv | 99 +++++++++
 tb/tb_req_arbiter4.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_defs.sv
// rtl/arb_defs.sv - shared state encodings and codes for the request arbiter
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] NO_GNT = 3'b111;

endpackage

// File: rtl/rot_pri_enc4.sv
// rtl/rot_pri_enc4.sv - 4-input priority search descending from a start index with wrap
module rot_pri_enc4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    win = 2'd0;
    any = 1'b0;
    idx = 2'd0;
    // Two-bit subtraction wraps naturally, giving the circular descending order.
    for (int k = 0; k < 4; k++) begin
      idx = start - 2'(k);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter4.sv
// rtl/req_arbiter4.sv - 4-way registered grant arbiter with fixed/round-robin priority and hold timer
module req_arbiter4
  import arb_defs::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic [2:0] gnt_code,
  output logic       busy,
  output logic       expired
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       last, last_nxt;
  logic [3:0]       gnt_nxt;
  logic [2:0]       code_nxt;
  logic             exp_nxt;
  logic [1:0]       start;
  logic [1:0]       win;
  logic             any;
  logic             timeout;

  assign start   = rr_en ? (last - 2'd1) : 2'd3;
  assign timeout = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  assign busy    = (state != ST_IDLE);

  rot_pri_enc4 u_enc (
    .req   (req),
    .start (start),
    .win   (win),
    .any   (any)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    gnt_nxt   = gnt;
    code_nxt  = gnt_code;
    exp_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          gnt_nxt   = 4'b0001 << win;
          code_nxt  = {1'b0, win};
          last_nxt  = win;
          cnt_nxt   = '0;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_nxt = cnt + 1'b1;
        // Release wins over a coincident timeout, so expired only flags a true preemption.
        if (!req[last] || timeout) begin
          exp_nxt   = req[last];
          gnt_nxt   = '0;
          code_nxt  = NO_GNT;
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        code_nxt  = NO_GNT;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last     <= 2'd0;
      gnt      <= '0;
      gnt_code <= NO_GNT;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      gnt      <= gnt_nxt;
      gnt_code <= code_nxt;
      expired  <= exp_nxt;
    end
  end

endmodule

// File: tb/tb_req_arbiter4.sv
// tb/tb_req_arbiter4.sv - randomized self-checking bench for req_arbiter4 against a cycle model
module tb_req_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rr_en = 1'b0;
  logic [3:0] gnt;
  logic [2:0] gnt_code;
  logic       busy;
  logic       expired;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: who owns the resource, for how many cycles, and whether we sit in the gap.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_last  = 0;
  int m_exp   = 0;

  always #5 clk = ~clk;

  req_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rr_en    (rr_en),
    .gnt      (gnt),
    .gnt_code (gnt_code),
    .busy     (busy),
    .expired  (expired)
  );

  function automatic logic [8:0] obs();
    return {gnt, gnt_code, busy, expired};
  endfunction

  function automatic logic [8:0] expv();
    logic [3:0] g;
    logic [2:0] c;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    c = (m_owner < 0) ? 3'b111 : 3'(m_owner);
    return {g, c, 1'(m_owner >= 0 || m_gap != 0), 1'(m_exp)};
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = 0; m_exp = 0;
  endfunction

  function automatic void model_update(logic [3:0] r, logic rr);
    int idx;
    m_exp = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
        m_owner = -1; m_gap = 1; m_exp = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (r != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr ? (m_last + 7 - k) % 4 : 3 - k;
        if (m_owner < 0 && r[idx]) m_owner = idx;
      end
      m_last = m_owner;
      m_held = 1;
    end
  endfunction

  task automatic step();
    model_update(req, rr_en);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    rr_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== {4'b0000, 3'b111, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), {4'b0000, 3'b111, 1'b0, 1'b0});
    end
  endtask

  task automatic test_fixed_release();
    do_reset();
    req = 4'b0110;
    rr_en = 1'b0;
    step();
    checks++;
    if ({gnt, gnt_code, busy} !== {4'b0100, 3'b010, 1'b1}) begin
      failures++;
      $display("FAIL fixed_first_grant got=%h exp=%h", {gnt, gnt_code, busy}, {4'b0100, 3'b010, 1'b1});
    end
    step();
    step();
    req = 4'b0010;
    step();
    checks++;
    if ({gnt, gnt_code, busy} !== {4'b0000, 3'b111, 1'b1}) begin
      failures++;
      $display("FAIL release_gap got=%h exp=%h", {gnt, gnt_code, busy}, {4'b0000, 3'b111, 1'b1});
    end
    step();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL release_idle got=%h exp=%h", obs(), expv());
    end
    step();
    checks++;
    if ({gnt, gnt_code} !== {4'b0010, 3'b001}) begin
      failures++;
      $display("FAIL regrant_after_release got=%h exp=%h", {gnt, gnt_code}, {4'b0010, 3'b001});
    end
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 4'b1000;
    step();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (gnt == 4'b1000) n++;
      else break;
    end
    checks++;
    if (n != MAX_HOLD) begin
      failures++;
      $display("FAIL timeout_hold_len got=%0d exp=%0d", n, MAX_HOLD);
    end
    checks++;
    if ({gnt, expired, busy} !== {4'b0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL timeout_expired got=%h exp=%h", {gnt, expired, busy}, {4'b0000, 1'b1, 1'b1});
    end
    step();
    step();
    checks++;
    if ({gnt, expired} !== {4'b1000, 1'b0}) begin
      failures++;
      $display("FAIL timeout_regrant got=%h exp=%h", {gnt, expired}, {4'b1000, 1'b0});
    end
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_round_robin();
    int owners[$];
    logic [3:0] prev;
    int want[5] = '{3, 2, 1, 0, 3};
    do_reset();
    rr_en = 1'b1;
    req = 4'b1111;
    prev = 4'b0000;
    for (int i = 0; i < 45; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (prev == 4'b0000 && gnt != 4'b0000) begin
        for (int k = 0; k < 4; k++) if (gnt[k]) owners.push_back(k);
      end
      prev = gnt;
    end
    checks++;
    if (owners.size() < 5) begin
      failures++;
      $display("FAIL rr_grant_count got=%0d exp=5", owners.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (owners[k] != want[k]) begin
          failures++;
          $display("FAIL rr_owner_seq idx=%0d got=%0d exp=%0d", k, owners[k], want[k]);
        end
      end
    end
    req = 4'b0000;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({gnt, gnt_code, busy, expired} !== {4'b0000, 3'b111, 1'b0, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_quiet got=%0d_bad_cycles exp=0", bad);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Bias toward keeping the request so holds reach the timer.
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rr_en = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random_model cyc=%0d req=%b got=%h exp=%h", cyc, req, obs(), expv());
      end
      checks++;
      if (((gnt & (gnt - 4'd1)) != 4'b0000) || ((gnt_code == 3'b111) != (gnt == 4'b0000))) begin
        failures++;
        $display("FAIL random_invariant cyc=%0d gnt=%b code=%b", cyc, gnt, gnt_code);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    rr_en = 1'b0;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, gnt_code, busy, expired} !== {4'b0000, 3'b111, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h exp=%h", {gnt, gnt_code, busy, expired},
               {4'b0000, 3'b111, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rr_en = 1'b1;
    req = 4'b1111;
    step();
    checks++;
    if ({gnt, gnt_code} !== {4'b1000, 3'b011}) begin
      failures++;
      $display("FAIL async_reset_first_grant got=%h exp=%h", {gnt, gnt_code}, {4'b1000, 3'b011});
    end
  endtask

  initial begin
    test_reset();
    test_fixed_release();
    test_timeout();
    test_round_robin();
    test_idle();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
